ex_issue_ctrl: RTL

//  Sequences the EX-stage datapath: accepts decoded ops from ID over a valid/ready handshake
//  and drives the ALU/shifter/multiplier controls (alu_sel, shift, mult, immed_sel, sh_dir,
//  sh_func, PSR_Wen) with stable registered values. Multiply is modelled as multi-cycle;
//  the block stalls ID until the result is taken by MEM over a second valid/ready handshake.

---
 rtl/ex_issue_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - EX-stage issue sequencer with multi-cycle multiply and result handshake
module ex_issue_ctrl #(
    parameter int MULT_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op_class,
    input  logic [6:0]       in_alu_sel,
    input  logic             in_immed_sel,
    input  logic             in_sh_dir,
    input  logic [2:0]       in_sh_func,
    input  logic             in_set_flags,
    output logic [6:0]       alu_sel,
    output logic             immed_sel,
    output logic             sh_dir,
    output logic [2:0]       sh_func,
    output logic             shift,
    output logic             mult,
    output logic             PSR_Wen,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MWAIT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_SHIFT = 2'b01;
    localparam logic [1:0] CLS_MULT  = 2'b10;
    localparam logic [1:0] CLS_NOP   = 2'b11;
    localparam logic [3:0] MCNT_INIT = 4'(MULT_LAT - 1);

    state_t           state_q;
    logic [3:0]       mcnt_q;
    logic [6:0]       alu_sel_q;
    logic             immed_sel_q;
    logic             sh_dir_q;
    logic [2:0]       sh_func_q;
    logic             shift_q;
    logic             mult_q;
    logic             set_flags_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic             accept;
    logic             op_nop;
    state_t           acc_state_d;
    logic [3:0]       acc_mcnt_d;

    // Handshake towards ID and MEM; a flush or reset always blocks new work
    assign in_ready  = resetn & ~flush &
                       ((state_q == ST_IDLE) | ((state_q == ST_EXEC) & res_ready));
    assign accept    = in_valid & in_ready;
    assign op_nop    = (in_op_class == CLS_NOP);
    assign res_valid = (state_q == ST_EXEC);
    assign PSR_Wen   = resetn & ~flush & (state_q == ST_EXEC) & res_ready & set_flags_q;

    assign alu_sel   = alu_sel_q;
    assign immed_sel = immed_sel_q;
    assign sh_dir    = sh_dir_q;
    assign sh_func   = sh_func_q;
    assign shift     = shift_q;
    assign mult      = mult_q;
    assign done_cnt  = done_cnt_q;

    // Destination state and wait count for whatever op is being accepted this cycle
    always_comb begin
        acc_state_d = ST_EXEC;
        acc_mcnt_d  = 4'd0;
        if (op_nop) begin
            acc_state_d = ST_IDLE;
        end else if (in_op_class == CLS_MULT && MULT_LAT > 1) begin
            acc_state_d = ST_MWAIT;
            acc_mcnt_d  = MCNT_INIT;
        end
    end

    // Sequencer: reset beats flush, flush beats accept and the result handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mcnt_q      <= 4'd0;
            alu_sel_q   <= 7'd0;
            immed_sel_q <= 1'b0;
            sh_dir_q    <= 1'b0;
            sh_func_q   <= 3'd0;
            shift_q     <= 1'b0;
            mult_q      <= 1'b0;
            set_flags_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            // NOPs leave the datapath controls untouched so nothing downstream glitches
            if (accept && !op_nop) begin
                alu_sel_q   <= in_alu_sel;
                immed_sel_q <= in_immed_sel;
                sh_dir_q    <= in_sh_dir;
                sh_func_q   <= in_sh_func;
                shift_q     <= (in_op_class == CLS_SHIFT);
                mult_q      <= (in_op_class == CLS_MULT);
                set_flags_q <= in_set_flags;
            end

            if (flush) begin
                state_q <= ST_IDLE;
                mcnt_q  <= 4'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            state_q <= acc_state_d;
                            mcnt_q  <= acc_mcnt_d;
                        end
                    end
                    ST_MWAIT: begin
                        mcnt_q <= mcnt_q - 4'd1;
                        if (mcnt_q == 4'd1) begin
                            state_q <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (res_ready) begin
                            done_cnt_q <= done_cnt_q + CNT_W'(1);
                            if (accept) begin
                                state_q <= acc_state_d;
                                mcnt_q  <= acc_mcnt_d;
                            end else begin
                                state_q <= ST_IDLE;
                                mcnt_q  <= 4'd0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        mcnt_q  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
